// File: rtl/pool_unit.sv
// 2x2 stride-2 pooling over a raster-order IN_SIZE x IN_SIZE feature map, streamed with valid/ready.
// Define POOL_AVG_EN to allow average pooling (selected by MAX_N_AVG == 0); otherwise always max-pools.
module pool_unit #(
  parameter int ACT_BITS  = 3,
  parameter int IN_SIZE   = 28,
  parameter int MAX_N_AVG = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ACT_BITS-1:0] in_act,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACT_BITS-1:0] out_act,
  output logic                out_last,
  output logic                done
);

`ifdef POOL_AVG_EN
  localparam bit AVG = (MAX_N_AVG == 0);
`else
  // MAX_N_AVG is referenced only so the parameter stays visible; the result is always 0.
  localparam bit AVG = 1'b0 && (MAX_N_AVG == 0);
`endif

  localparam int CW = (IN_SIZE > 2) ? $clog2(IN_SIZE) : 1;
  localparam int BW = (IN_SIZE > 2) ? $clog2(IN_SIZE / 2) : 1;
  localparam int HW = AVG ? ACT_BITS + 1 : ACT_BITS;
  localparam int WW = ACT_BITS + 2;
  localparam logic [CW-1:0] LAST_IDX = CW'(IN_SIZE - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t              state;
  logic [CW-1:0]       col;
  logic [CW-1:0]       row;
  logic [ACT_BITS-1:0] hold;
  logic [HW-1:0]       line_buf [IN_SIZE/2];

  logic                beat;
  logic                end_pix;
  logic [BW-1:0]       bidx;
  logic [HW-1:0]       buf_rd;
  logic [HW-1:0]       h;
  logic [WW-1:0]       h_w;
  logic [WW-1:0]       win_w;
  logic [ACT_BITS-1:0] out_next;

  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign beat     = in_valid && in_ready;
  assign end_pix  = (col == LAST_IDX) && (row == LAST_IDX);
  assign bidx     = BW'(col >> 1);

  // Both reductions are evaluated at ACT_BITS+2 bits so one datapath serves sum and max.
  always_comb begin
    buf_rd = line_buf[bidx];
    if (AVG) begin
      h_w      = WW'(hold) + WW'(in_act);
      win_w    = WW'(buf_rd) + h_w;
      out_next = win_w[WW-1:2];
    end else begin
      h_w      = (in_act > hold) ? WW'(in_act) : WW'(hold);
      win_w    = (WW'(buf_rd) > h_w) ? WW'(buf_rd) : h_w;
      out_next = win_w[ACT_BITS-1:0];
    end
    h = h_w[HW-1:0];
  end

  always_ff @(posedge clk) begin
    if (beat && col[0] && !row[0]) line_buf[bidx] <= h;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      hold      <= '0;
      out_valid <= 1'b0;
      out_act   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;

      if (beat && !col[0]) hold <= in_act;

      if (beat && col[0] && row[0]) begin
        out_act   <= out_next;
        out_last  <= end_pix;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (beat) begin
        if (col == LAST_IDX) begin
          col <= '0;
          row <= (row == LAST_IDX) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      unique case (state)
        IDLE: if (start) begin
          state <= RUN;
          col   <= '0;
          row   <= '0;
        end
        RUN: if (beat && end_pix) state <= FLUSH;
        FLUSH: if (out_valid && out_ready && out_last) begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_unit.sv
// Scoreboard bench for pool_unit: 4x4 and 28x28 instances driven with random and directed frames.
module tb_pool_unit;

  localparam int A   = 3;
  localparam int SZ0 = 4;
  localparam int SZ1 = 28;
`ifdef POOL_AVG_EN
  localparam int MNA = 0;
  localparam bit AVG = 1'b1;
`else
  localparam int MNA = 1;
  localparam bit AVG = 1'b0;
`endif

  typedef logic [A:0] exp_t;

  logic         clk = 1'b0;
  logic         rst_n     [2];
  logic         start_s   [2];
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [A-1:0] in_act    [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [A-1:0] out_act   [2];
  logic         out_last  [2];
  logic         done_s    [2];

  int     passes = 0;
  int     total  = 0;
  int     out_cnt    [2];
  bit     done_seen  [2];
  bit     stall_arm  [2];
  int     stall_cnt  [2];
  bit     rand_rdy   [2];
  exp_t   sbq [2][$];
  logic [A-1:0] img [SZ1*SZ1];

  always #5 clk = ~clk;

  pool_unit #(.ACT_BITS(A), .IN_SIZE(SZ0), .MAX_N_AVG(MNA)) u4 (
    .clk(clk), .rst_n(rst_n[0]), .start(start_s[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .in_act(in_act[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_act(out_act[0]), .out_last(out_last[0]), .done(done_s[0])
  );

  pool_unit #(.ACT_BITS(A), .IN_SIZE(SZ1), .MAX_N_AVG(MNA)) u28 (
    .clk(clk), .rst_n(rst_n[1]), .start(start_s[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .in_act(in_act[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_act(out_act[1]), .out_last(out_last[1]), .done(done_s[1])
  );

  function automatic int sz(int k);
    return (k == 0) ? SZ0 : SZ1;
  endfunction

  function automatic void chk(string nm, int got, int expv);
    total++;
    if (got == expv) passes++;
    else $display("FAIL %s: got %0d, expected %0d", nm, got, expv);
  endfunction

  // Reference: every 2x2 window reduced by max (or truncated mean), windows in raster order.
  task automatic push_model(int k);
    int n = sz(k);
    for (int r = 0; r < n / 2; r++) begin
      for (int c = 0; c < n / 2; c++) begin
        int w [4];
        int expv;
        bit last;
        w[0] = int'(img[(2*r)*n + 2*c]);
        w[1] = int'(img[(2*r)*n + 2*c + 1]);
        w[2] = int'(img[(2*r+1)*n + 2*c]);
        w[3] = int'(img[(2*r+1)*n + 2*c + 1]);
        if (AVG) expv = (w[0] + w[1] + w[2] + w[3]) / 4;
        else begin
          expv = w[0];
          for (int j = 1; j < 4; j++) if (w[j] > expv) expv = w[j];
        end
        last = (r == n/2 - 1) && (c == n/2 - 1);
        sbq[k].push_back({last, expv[A-1:0]});
      end
    end
  endtask

  task automatic run_frame(int k, int abort_at, int start_at, bit gaps);
    int n = sz(k);
    int guard;
    bit acc;
    done_seen[k] = 1'b0;
    out_cnt[k]   = 0;
    @(posedge clk); #1;
    start_s[k] = 1'b1;
    @(posedge clk); #1;
    start_s[k] = 1'b0;
    push_model(k);
    for (int i = 0; i < n * n; i++) begin
      if (i == abort_at) begin
        in_valid[k] = 1'b0;
        return;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid[k] = 1'b0;
        @(posedge clk); #1;
      end
      in_valid[k] = 1'b1;
      in_act[k]   = img[i];
      if (i == start_at) start_s[k] = 1'b1;
      acc   = 1'b0;
      guard = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready[k];
        @(posedge clk); #1;
        start_s[k] = 1'b0;
        guard++;
        if (!acc && guard > 200) begin
          total++;
          $display("FAIL in_ready_timeout dut%0d pixel %0d: got in_ready 0, expected 1", k, i);
          in_valid[k] = 1'b0;
          return;
        end
      end
    end
    in_valid[k] = 1'b0;
    guard = 0;
    while (!done_seen[k] && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    chk($sformatf("done_seen_dut%0d", k), int'(done_seen[k]), 1);
    chk($sformatf("out_count_dut%0d", k), out_cnt[k], (n / 2) * (n / 2));
    chk($sformatf("queue_empty_dut%0d", k), sbq[k].size(), 0);
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_tb
    bit           pstall = 1'b0;
    bit           exp_done = 1'b0;
    logic [A-1:0] pact;
    logic         plast;
    exp_t         e;

    always @(posedge clk) begin
      #1;
      if (stall_cnt[k] > 0) begin
        out_ready[k] = 1'b0;
        stall_cnt[k]--;
      end else if (stall_arm[k] && out_valid[k]) begin
        stall_arm[k] = 1'b0;
        stall_cnt[k] = 9;
        out_ready[k] = 1'b0;
      end else begin
        out_ready[k] = rand_rdy[k] ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end

    always @(negedge clk) begin
      if (!rst_n[k]) begin
        pstall   = 1'b0;
        exp_done = 1'b0;
      end else begin
        if (exp_done || done_s[k]) chk($sformatf("done_pulse_dut%0d", k), int'(done_s[k]), int'(exp_done));
        if (done_s[k]) done_seen[k] = 1'b1;
        exp_done = 1'b0;
        if (pstall) begin
          chk($sformatf("stall_valid_dut%0d", k), int'(out_valid[k]), 1);
          chk($sformatf("stall_act_dut%0d", k), int'(out_act[k]), int'(pact));
          chk($sformatf("stall_last_dut%0d", k), int'(out_last[k]), int'(plast));
        end
        if (out_valid[k] && !out_ready[k]) chk($sformatf("stall_in_ready_dut%0d", k), int'(in_ready[k]), 0);
        if (out_valid[k] && out_ready[k]) begin
          if (sbq[k].size() == 0) begin
            total++;
            $display("FAIL unexpected_output dut%0d: got act %0d, expected no output", k, out_act[k]);
          end else begin
            e = sbq[k].pop_front();
            chk($sformatf("out_act_dut%0d", k), int'(out_act[k]), int'(e[A-1:0]));
            chk($sformatf("out_last_dut%0d", k), int'(out_last[k]), int'(e[A]));
          end
          out_cnt[k]++;
          if (out_last[k]) exp_done = 1'b1;
        end
        pstall = out_valid[k] && !out_ready[k];
        pact   = out_act[k];
        plast  = out_last[k];
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; start_s[k] = 1'b0; in_valid[k] = 1'b0; in_act[k] = '0;
      out_ready[k] = 1'b1; stall_arm[k] = 1'b0; stall_cnt[k] = 0; rand_rdy[k] = 1'b0;
      out_cnt[k] = 0; done_seen[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) rst_n[k] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_out_valid_dut%0d", k), int'(out_valid[k]), 0);
      chk($sformatf("rst_out_act_dut%0d", k), int'(out_act[k]), 0);
      chk($sformatf("rst_out_last_dut%0d", k), int'(out_last[k]), 0);
      chk($sformatf("rst_done_dut%0d", k), int'(done_s[k]), 0);
      chk($sformatf("rst_in_ready_dut%0d", k), int'(in_ready[k]), 0);
    end

    // 4x4 ramp, values wrap mod 8, consumer always ready
    for (int i = 0; i < SZ0 * SZ0; i++) img[i] = A'(i);
    run_frame(0, -1, -1, 1'b0);

    // 4x4 with windows {7,7,7,6} and {1,0,0,0} on the top row of windows
    for (int i = 0; i < SZ0 * SZ0; i++) img[i] = A'($urandom);
    img[0] = 3'd7; img[1] = 3'd7; img[4] = 3'd7; img[5] = 3'd6;
    img[2] = 3'd1; img[3] = 3'd0; img[6] = 3'd0; img[7] = 3'd0;
    rand_rdy[0] = 1'b1;
    run_frame(0, -1, -1, 1'b1);

    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < SZ0 * SZ0; i++) img[i] = A'($urandom);
      run_frame(0, -1, -1, f[0]);
    end

    // 28x28 all 7 except the final pixel
    for (int i = 0; i < SZ1 * SZ1; i++) img[i] = 3'd7;
    img[SZ1*SZ1-1] = 3'd0;
    run_frame(1, -1, -1, 1'b0);

    // random frame with a stray start mid-run and a 10-cycle consumer stall
    for (int i = 0; i < SZ1 * SZ1; i++) img[i] = A'($urandom);
    stall_arm[1] = 1'b1;
    rand_rdy[1]  = 1'b1;
    run_frame(1, -1, 100, 1'b1);

    // reset in row 9, then a full frame
    for (int i = 0; i < SZ1 * SZ1; i++) img[i] = A'($urandom);
    run_frame(1, 9 * SZ1 + 3, -1, 1'b1);
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    #1;
    sbq[1].delete();
    chk("abort_out_valid", int'(out_valid[1]), 0);
    chk("abort_in_ready", int'(in_ready[1]), 0);
    chk("abort_out_last", int'(out_last[1]), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n[1] = 1'b1;
    repeat (5) @(posedge clk);
    for (int i = 0; i < SZ1 * SZ1; i++) img[i] = A'($urandom);
    run_frame(1, -1, -1, 1'b1);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
